// File: rtl/limb_serial_adder_pkg.sv
// Shared definitions for the limb-serial multi-precision adder: default
// geometry, limb/counter sizing helpers and the controller state encoding.
package limb_serial_adder_pkg;

  // Default geometry: a 256-bit add streamed as 8-bit limbs.
  localparam int DEF_OPERAND_WIDTH = 256;
  localparam int DEF_LIMB_WIDTH    = 8;
  localparam int N_LIMBS           = DEF_OPERAND_WIDTH / DEF_LIMB_WIDTH;
  localparam int CNT_W             = $clog2(N_LIMBS);

  // Controller states. Encoding is fixed so a checker can decode it directly.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of limbs for a given operand/limb geometry.
  function automatic int calc_n_limbs(input int operand_width, input int limb_width);
    return operand_width / limb_width;
  endfunction

  // Limb counter width for a given operand/limb geometry.
  function automatic int calc_cnt_w(input int operand_width, input int limb_width);
    return $clog2(operand_width / limb_width);
  endfunction

  // Legal geometry: whole limbs only, and at least two of them.
  function automatic bit geometry_ok(input int operand_width, input int limb_width);
    return (limb_width > 0) && (operand_width % limb_width == 0) &&
           (operand_width / limb_width >= 2);
  endfunction

endpackage

// File: rtl/adder_8bit.sv
// Single-limb carry-lookahead adder. Every carry is formed directly from the
// generate/propagate terms and the carry-in rather than rippling bit to bit.
module adder_8bit #(
  parameter int ADDER_WIDTH = 8
) (
  input  logic [ADDER_WIDTH-1:0] iA,
  input  logic [ADDER_WIDTH-1:0] iB,
  input  logic                   iC,
  output logic [ADDER_WIDTH-1:0] oSum,
  output logic                   oC
);

  logic [ADDER_WIDTH-1:0] gen;
  logic [ADDER_WIDTH-1:0] prop;
  logic [ADDER_WIDTH:0]   carry;
  logic                   acc;
  logic                   pchain;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0.
  always_comb begin
    gen      = iA & iB;
    prop     = iA ^ iB;
    carry    = '0;
    carry[0] = iC;
    acc      = 1'b0;
    pchain   = 1'b1;
    for (int i = 0; i < ADDER_WIDTH; i++) begin
      acc    = 1'b0;
      pchain = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc    = acc | (pchain & gen[j]);
        pchain = pchain & prop[j];
      end
      carry[i+1] = acc | (pchain & iC);
    end
    oSum = prop ^ carry[ADDER_WIDTH-1:0];
    oC   = carry[ADDER_WIDTH];
  end

endmodule

// File: rtl/limb_serial_adder.sv
// Multi-precision adder that streams LIMB_WIDTH-bit limbs, least significant
// first, through one adder_8bit instance, one limb per clock, keeping the
// inter-limb carry in a register.
//
// Handshake: a transfer happens only on a rising edge where valid and ready
// are both high. Input side: iValid/oReady, operands sampled only at that
// edge (iValid while busy is ignored, not queued). Output side: oValid/iReady,
// oSum/oC hold stable while oValid waits for iReady.
module limb_serial_adder
  import limb_serial_adder_pkg::*;
#(
  parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH,
  parameter int LIMB_WIDTH    = DEF_LIMB_WIDTH
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iValid,
  output logic                     oReady,
  input  logic [OPERAND_WIDTH-1:0] iA,
  input  logic [OPERAND_WIDTH-1:0] iB,
  input  logic                     iC,
  output logic                     oValid,
  input  logic                     iReady,
  output logic [OPERAND_WIDTH-1:0] oSum,
  output logic                     oC
);

  localparam int LIMBS = calc_n_limbs(OPERAND_WIDTH, LIMB_WIDTH);
  localparam int CW    = calc_cnt_w(OPERAND_WIDTH, LIMB_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(LIMBS - 1);

  // Reject impossible geometries at elaboration time.
  if (!geometry_ok(OPERAND_WIDTH, LIMB_WIDTH)) begin : g_bad_geometry
    $error("limb_serial_adder: OPERAND_WIDTH must be a multiple of LIMB_WIDTH with at least two limbs");
  end
  if (N_LIMBS * DEF_LIMB_WIDTH != DEF_OPERAND_WIDTH || CNT_W != $clog2(N_LIMBS)) begin : g_bad_defaults
    $error("limb_serial_adder_pkg: default geometry is inconsistent");
  end

  // Controller state; state_q is the point to observe for FSM checkers.
  state_t                   state_q;
  state_t                   state_d;

  logic [OPERAND_WIDTH-1:0] a_q;
  logic [OPERAND_WIDTH-1:0] b_q;
  logic [OPERAND_WIDTH-1:0] sum_q;
  logic                     carry_q;
  logic [CW-1:0]            cnt_q;

  logic [LIMB_WIDTH-1:0]    limb_sum;
  logic                     limb_carry;

  // The limb adder sees register outputs only and feeds registers only.
  adder_8bit #(
    .ADDER_WIDTH(LIMB_WIDTH)
  ) u_limb_adder (
    .iA  (a_q[LIMB_WIDTH-1:0]),
    .iB  (b_q[LIMB_WIDTH-1:0]),
    .iC  (carry_q),
    .oSum(limb_sum),
    .oC  (limb_carry)
  );

  // State register; reset wins over everything.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d = state_q;
    oReady  = 1'b0;
    oValid  = 1'b0;
    case (state_q)
      IDLE: begin
        oReady = 1'b1;
        if (iValid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        oValid = 1'b1;
        // Leaving DONE only returns to IDLE; a new operand waits for oReady.
        if (iReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand/result shift registers, carry register and limb counter.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (iValid) begin
            a_q     <= iA;
            b_q     <= iB;
            carry_q <= iC;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          // Each limb result enters at the top; after LIMBS shifts limb 0
          // has reached the bottom of the result register.
          sum_q   <= {limb_sum, sum_q[OPERAND_WIDTH-1:LIMB_WIDTH]};
          a_q     <= a_q >> LIMB_WIDTH;
          b_q     <= b_q >> LIMB_WIDTH;
          carry_q <= limb_carry;
          cnt_q   <= cnt_q + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign oSum = sum_q;
  assign oC   = carry_q;

endmodule

// File: doc/limb_serial_adder.md
Name: limb_serial_adder

Overview:
- Sequential multi-precision adder that splits two wide operands into LIMB_WIDTH-bit limbs.
- Streams the limbs least-significant first through one instance of the 8-bit carry-lookahead adder, one limb per clock, registering the carry between limbs.
- Sits directly upstream of adder_8bit: it drives adder_8bit's iA/iB/iC every cycle and consumes oSum/oC.
- Trades latency for area on wide (e.g. 256-bit) additions.

Parameters:
- OPERAND_WIDTH, 256, total operand/result width; must be an integer multiple of LIMB_WIDTH, and OPERAND_WIDTH/LIMB_WIDTH >= 2.
- LIMB_WIDTH, 8, width of one limb; equals the ADDER_WIDTH passed to the adder_8bit instance.

Ports:
- iClk  input  1  sole clock; all state updates on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iValid  input  1  operands present on iA/iB/iC.
- oReady  output  1  block can accept operands this cycle.
- iA  input  OPERAND_WIDTH  operand A.
- iB  input  OPERAND_WIDTH  operand B.
- iC  input  1  carry-in to limb 0.
- oValid  output  1  result on oSum/oC is valid.
- iReady  input  1  downstream accepts the result.
- oSum  output  OPERAND_WIDTH  A+B+iC modulo 2^OPERAND_WIDTH.
- oC  output  1  carry-out of the most significant limb.

Behaviour:
- Clocking and reset: single clock iClk. Reset iRst is synchronous and active-high; there is no asynchronous reset path.
- N = OPERAND_WIDTH/LIMB_WIDTH. Limb counter width is $clog2(N).
- Reset state: IDLE, oReady=1, oValid=0, oSum=0, oC=0, limb counter=0, carry register=0, operand registers=0.
- FSM states:
  - IDLE: oReady=1, oValid=0. On iValid=1, accept: latch iA and iB into operand shift registers, latch iC into the carry register, clear the counter, go to RUN. If iValid=0, stay in IDLE.
  - RUN: oReady=0, oValid=0. Each cycle the bottom LIMB_WIDTH bits of the A and B shift registers and the carry register drive adder_8bit.
    - On the edge: its oSum is shifted into the top limb of the result shift register (result shifts right by LIMB_WIDTH); A and B shift right by LIMB_WIDTH; carry register <= adder oC; counter++.
    - When counter==N-1 on the edge, go to DONE.
  - DONE: oValid=1, oReady=0. oSum = result register; oC = carry register. On iReady=1, go to IDLE. oSum/oC hold their values until the next result overwrites them; they are not cleared.
- Latency:
  - Accept edge at cycle 0 → oValid=1 in the cycle after edge N (N RUN cycles).
  - Minimum accept-to-accept interval is N+2 cycles when iReady is held high.
- Handshake rules:
  - Transfer occurs only when valid & ready are both high on the same edge.
  - iA/iB/iC are sampled only at acceptance; they may change freely afterwards.
  - iValid during RUN/DONE is ignored and not queued; the upstream must hold it until oReady.
- Wrap-around: the sum is modulo 2^OPERAND_WIDTH; overflow is reported only via oC. Carry propagates across all N limbs, including a full-length ripple (e.g. all-ones + 1).
- Simultaneous events:
  - iRst has priority over everything.
  - In DONE with iReady=1 and iValid=1 in the same cycle, the block only returns to IDLE; the new operand is accepted on a later cycle.
- Reset mid-operation: any state → IDLE on the next edge. The partial result is discarded, oValid drops immediately after the edge, and no result is emitted for the aborted operation.
- Combinational path: adder_8bit inputs are register outputs only; adder outputs feed registers only. No port-to-port combinational path.

Decomposition:
- Shared package holds:
  - localparams N_LIMBS and CNT_W.
  - State encoding enum {IDLE, RUN, DONE} (2-bit).
  - An elaboration check that OPERAND_WIDTH % LIMB_WIDTH == 0 and N_LIMBS >= 2.
- One sub-module: the existing adder_8bit, instantiated once with ADDER_WIDTH=LIMB_WIDTH.
- FSM, counter and shift registers live in limb_serial_adder.

Test Plan:
1. OPERAND_WIDTH=32: reset, then accept A=0x0000_0001, B=0x0000_0002, iC=0 → oValid rises 4 cycles after acceptance with oSum=0x0000_0003, oC=0.
2. A=0xFFFF_FFFF, B=0x0000_0000, iC=1 → oSum=0x0000_0000, oC=1 (carry ripples through all 4 limbs).
3. A=0x8000_0000, B=0x8000_0000, iC=0 → oSum=0, oC=1. Then A=0x00FF_00FF, B=0x0001_0001, iC=0 → oSum=0x0100_0100, oC=0.
4. Backpressure: hold iReady=0 for 10 cycles in DONE → oValid stays 1 and oSum stable, with oReady=0. A new iValid pulse during DONE is ignored. Raising iReady → IDLE next edge, oReady=1.
5. Assert iRst for 1 cycle during RUN (after 2 limbs) → next cycle IDLE with oValid=0, oSum=0, oC=0. A subsequent operation returns a correct result.
6. OPERAND_WIDTH=256: 1000 random A/B/iC transactions with random iValid/iReady gaps → every result matches A+B+iC against a reference model. Accept-to-oValid is always exactly 32 cycles.
